// File: rtl/async_fifo_wr_arbiter.sv
// rtl/async_fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
//
// Purpose: grants the write port of custom_async_fifo to one of NREQ producers
// at a time, for at most BURST accepted words, rotating round-robin. Stalls on
// fifo_full_i and counts every committed write.
//
// Ports:
//   wclk_i       write-domain clock
//   wrst_i       synchronous active-high reset
//   req_i        per-requester valid
//   data_i       packed data, requester k at [k*SIZE +: SIZE]
//   gnt_o        registered one-hot grant, zero when idle
//   fifo_full_i  FIFO full flag, used unregistered
//   wen_o        FIFO write enable (combinational)
//   din_o        FIFO write data (combinational)
//   busy_o       registered, high while a grant is held
//   wr_count_o   registered count of accepted words, wraps at 2^16

module async_fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int SIZE  = 8,
    parameter int BURST = 4
) (
    input  logic                 wclk_i,
    input  logic                 wrst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*SIZE-1:0] data_i,
    output logic [NREQ-1:0]      gnt_o,
    input  logic                 fifo_full_i,
    output logic                 wen_o,
    output logic [SIZE-1:0]      din_o,
    output logic                 busy_o,
    output logic [15:0]          wr_count_o
);

    localparam int IW  = (NREQ  > 1) ? $clog2(NREQ)  : 1;
    localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [IW-1:0]  LAST_IDX   = IW'(NREQ - 1);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST - 1);

    logic [0:0]      state_q,     state_d;
    logic [NREQ-1:0] gnt_q,       gnt_d;
    logic [IW-1:0]   gidx_q,      gidx_d;
    logic [IW-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;
    logic [15:0]     wr_count_q,  wr_count_d;

    logic            granted_req;
    logic            accept;
    logic            rel_burst;
    logic            rel_drop;
    logic [IW-1:0]   scan_start;
    logic [NREQ-1:0] scan_mask;
    logic [IW:0]     pick;

    // Index increment modulo NREQ (NREQ need not be a power of two).
    function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IW'(1);
    endfunction

    // First set bit of mask scanning upward from start with wrap.
    // Returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] mask,
                                            input logic [IW-1:0]   start);
        logic [IW-1:0] idx;
        logic [IW-1:0] sel;
        logic          found;
        idx   = start;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && mask[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
            idx = inc_idx(idx);
        end
        return {found, sel};
    endfunction

    // gnt_q is non-zero exactly in GRANT, so this is req of the granted index.
    assign granted_req = |(gnt_q & req_i);
    assign accept      = granted_req & ~fifo_full_i & ~wrst_i;
    assign wen_o       = accept;
    assign din_o       = (state_q == ST_GRANT) ? data_i[gidx_q*SIZE +: SIZE] : '0;

    assign gnt_o      = gnt_q;
    assign busy_o     = (state_q == ST_GRANT);
    assign wr_count_o = wr_count_q;

    // A full FIFO blocks accept but not the drop release, so a producer that
    // withdraws while stalled still hands the port on.
    assign rel_burst = accept & (burst_cnt_q == BURST_LAST);
    assign rel_drop  = ~granted_req;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        wr_count_d  = accept ? wr_count_q + 16'd1 : wr_count_q;
        scan_start  = rr_ptr_q;
        scan_mask   = req_i;
        pick        = '0;

        if (state_q == ST_IDLE) begin
            pick = rr_pick(scan_mask, scan_start);
            if (pick[IW]) begin
                state_d     = ST_GRANT;
                gidx_d      = pick[IW-1:0];
                gnt_d       = NREQ'(1) << pick[IW-1:0];
                burst_cnt_d = '0;
            end
        end else begin
            if (rel_burst || rel_drop) begin
                scan_start = inc_idx(gidx_q);
                rr_ptr_d   = scan_start;
                // After a full burst the releasing requester stays eligible
                // (wraps last), so a sole active requester is re-granted.
                if (rel_drop) begin
                    scan_mask[gidx_q] = 1'b0;
                end
                pick        = rr_pick(scan_mask, scan_start);
                burst_cnt_d = '0;
                if (pick[IW]) begin
                    state_d = ST_GRANT;
                    gidx_d  = pick[IW-1:0];
                    gnt_d   = NREQ'(1) << pick[IW-1:0];
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end else if (accept) begin
                burst_cnt_d = burst_cnt_q + BCW'(1);
            end
        end
    end

    always_ff @(posedge wclk_i) begin
        if (wrst_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_count_q  <= wr_count_d;
        end
    end

endmodule
